// File: rtl/noc_packetizer_if.sv
// rtl/noc_packetizer_if.sv - descriptor, payload and NoC send channel bundle for noc_packetizer
interface noc_packetizer_if #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int LEN_W   = 8
);
    // descriptor channel (tile -> packetizer)
    logic               msg_valid;
    logic               msg_ready;
    logic [COORD_W-1:0] msg_dst_x;
    logic [COORD_W-1:0] msg_dst_y;
    logic [LEN_W-1:0]   msg_len;

    // payload channel (tile -> packetizer)
    logic               data_valid;
    logic               data_ready;
    logic [DATA_W-1:0]  data_in;

    // flit channel (packetizer -> NoC node receive port)
    logic               noc_send_valid;
    logic               noc_send_ready;
    logic [DATA_W-1:0]  noc_send_flit;
    logic               noc_send_VCready;
    logic               noc_send_is_header;
    logic               noc_send_is_tail;

    // packetizer side: sinks descriptors and payload, sources flits
    modport master (
        input  msg_valid, msg_dst_x, msg_dst_y, msg_len,
        output msg_ready,
        input  data_valid, data_in,
        output data_ready,
        output noc_send_valid, noc_send_flit, noc_send_is_header, noc_send_is_tail,
        input  noc_send_ready, noc_send_VCready
    );

    // environment side: compute tile plus NoC node
    modport slave (
        output msg_valid, msg_dst_x, msg_dst_y, msg_len,
        input  msg_ready,
        output data_valid, data_in,
        input  data_ready,
        input  noc_send_valid, noc_send_flit, noc_send_is_header, noc_send_is_tail,
        output noc_send_ready, noc_send_VCready
    );
endinterface

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - wormhole packet injector: header flit from descriptor, then payload flits
module noc_packetizer #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int LEN_W   = 8,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0
) (
    input  logic          noc_clk,
    input  logic          noc_rst,
    noc_packetizer_if.master bus,
    output logic [15:0]   pkt_count,
    output logic          busy
);
    localparam int HDR_W = LEN_W + 4 * COORD_W;

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic               send_valid;
    logic               send_is_header;
    logic               send_is_tail;
    logic [DATA_W-1:0]  send_flit;

    logic               can_load;
    logic               msg_fire;
    logic               data_fire;
    logic               tail_fire;
    logic [HDR_W-1:0]   header;

    // The single output stage may be refilled when empty or when its flit leaves this cycle
    assign can_load = !send_valid || bus.noc_send_ready;

    // Handshake readies depend only on registered state and downstream ready, never on the
    // upstream valids; VC availability gates only the start of a new packet
    assign bus.msg_ready  = !noc_rst && (state == IDLE) && bus.noc_send_VCready && can_load;
    assign bus.data_ready = !noc_rst && (state == BODY) && can_load;

    assign msg_fire  = bus.msg_valid && bus.msg_ready;
    assign data_fire = bus.data_valid && bus.data_ready;
    assign tail_fire = send_valid && bus.noc_send_ready && send_is_tail;

    // Header layout LSB first: dst_x, dst_y, src_x, src_y, len; upper bits zero
    assign header = {bus.msg_len, COORD_W'(SRC_Y), COORD_W'(SRC_X), bus.msg_dst_y, bus.msg_dst_x};

    assign bus.noc_send_valid     = send_valid;
    assign bus.noc_send_flit      = send_flit;
    assign bus.noc_send_is_header = send_is_header;
    assign bus.noc_send_is_tail   = send_is_tail;

    assign busy = (state != IDLE) || send_valid;

    // Packet FSM, flit output register and sent-packet counter
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state          <= IDLE;
            remaining      <= '0;
            send_valid     <= 1'b0;
            send_flit      <= '0;
            send_is_header <= 1'b0;
            send_is_tail   <= 1'b0;
            pkt_count      <= '0;
        end else begin
            if (tail_fire) begin
                pkt_count <= pkt_count + 16'd1;
            end

            // slot drains when its flit is taken; a new accept below refills it in the same cycle
            if (can_load) begin
                send_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (msg_fire) begin
                        send_valid     <= 1'b1;
                        send_flit      <= DATA_W'(header);
                        send_is_header <= 1'b1;
                        send_is_tail   <= (bus.msg_len == '0);
                        remaining      <= bus.msg_len;
                        if (bus.msg_len != '0) begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (data_fire) begin
                        send_valid     <= 1'b1;
                        send_flit      <= bus.data_in;
                        send_is_header <= 1'b0;
                        send_is_tail   <= (remaining == LEN_W'(1));
                        remaining      <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - scoreboard bench for noc_packetizer
module tb_noc_packetizer;
    localparam int DATA_W  = 32;
    localparam int COORD_W = 4;
    localparam int LEN_W   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_count;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hdr_cyc = 0;
    int tail_cyc = 0;
    int exp_pkts = 0;

    logic [DATA_W+1:0] sb[$];

    noc_packetizer_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .LEN_W(LEN_W)) bus ();

    noc_packetizer #(
        .DATA_W(DATA_W), .COORD_W(COORD_W), .LEN_W(LEN_W), .SRC_X(0), .SRC_Y(0)
    ) dut (
        .noc_clk(clk),
        .noc_rst(rst),
        .bus(bus),
        .pkt_count(pkt_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] hdr(input logic [3:0] x, input logic [3:0] y,
                                              input logic [7:0] len);
        logic [DATA_W-1:0] h;
        h = '0;
        h[3:0]   = x;
        h[7:4]   = y;
        h[23:16] = len;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flit monitor: pops the scoreboard on each handshake and checks stall stability
    logic              stall_prev = 1'b0;
    logic [DATA_W+1:0] held;
    logic [DATA_W+1:0] cur;
    logic [DATA_W+1:0] e;
    always @(negedge clk) begin
        cur = {bus.noc_send_is_header, bus.noc_send_is_tail, bus.noc_send_flit};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("stall_hold", {bus.noc_send_valid, cur}, {1'b1, held});
            if (bus.noc_send_valid && bus.noc_send_ready) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_flit observed=%0h expected=none", cur);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("flit", cur, e);
                end
                if (cur[DATA_W+1]) hdr_cyc = cyc;
                if (cur[DATA_W])   tail_cyc = cyc;
            end
            stall_prev = bus.noc_send_valid && !bus.noc_send_ready;
            held = cur;
        end
    end

    task automatic send_msg(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
        int n = 0;
        bus.msg_valid = 1'b1;
        bus.msg_dst_x = x;
        bus.msg_dst_y = y;
        bus.msg_len   = len;
        @(negedge clk);
        while (bus.msg_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("msg_accept", bus.msg_ready, 1);
        sb.push_back({1'b1, (len == 8'd0), hdr(x, y, len)});
        @(posedge clk);
        #1;
        bus.msg_valid = 1'b0;
        chk("hdr_latency", {bus.noc_send_valid, bus.noc_send_is_header}, 2'b11);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic tail);
        int n = 0;
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        @(negedge clk);
        while (bus.data_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("data_accept", bus.data_ready, 1);
        sb.push_back({1'b0, tail, d});
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.noc_send_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int n;
        bus.msg_valid        = 1'b0;
        bus.msg_dst_x        = '0;
        bus.msg_dst_y        = '0;
        bus.msg_len          = '0;
        bus.data_valid       = 1'b0;
        bus.data_in          = '0;
        bus.noc_send_ready   = 1'b1;
        bus.noc_send_VCready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_msg_ready", bus.msg_ready, 0);
        rst = 1'b0;
        chk("rst_valid", bus.noc_send_valid, 0);
        chk("rst_flit", bus.noc_send_flit, 0);
        chk("rst_flags", {bus.noc_send_is_header, bus.noc_send_is_tail}, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_ready", bus.data_ready, 0);

        // basic packet, back-to-back flits
        send_msg(4'd2, 4'd3, 8'd3);
        chk("t1_header", bus.noc_send_flit, 32'h0003_0032);
        chk("t1_busy", busy, 1);
        send_word(32'hA1, 1'b0);
        send_word(32'hA2, 1'b0);
        send_word(32'hA3, 1'b1);
        drain();
        exp_pkts++;
        chk("t1_pkt_count", pkt_count, exp_pkts);
        chk("t1_flit_spacing", tail_cyc - hdr_cyc, 3);

        // header-only packet
        send_msg(4'd1, 4'd1, 8'd0);
        chk("t2_header", bus.noc_send_flit, 32'h0000_0011);
        chk("t2_flags", {bus.noc_send_is_header, bus.noc_send_is_tail}, 2'b11);
        chk("t2_idle_data_ready", bus.data_ready, 0);
        chk("t2_idle_msg_ready", bus.msg_ready, 1);
        drain();
        exp_pkts++;
        chk("t2_pkt_count", pkt_count, exp_pkts);
        chk("t2_busy", busy, 0);

        // VC not ready holds off the descriptor
        bus.noc_send_VCready = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_dst_x = 4'd4;
        bus.msg_dst_y = 4'd5;
        bus.msg_len   = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_msg_ready", bus.msg_ready, 0);
            chk("t3_no_flit", bus.noc_send_valid, 0);
        end
        @(posedge clk);
        #1;
        bus.noc_send_VCready = 1'b1;
        send_msg(4'd4, 4'd5, 8'd1);
        send_word(32'h0000_0055, 1'b1);
        drain();
        exp_pkts++;
        chk("t3_pkt_count", pkt_count, exp_pkts);

        // downstream stalls mid-body; VC drop does not stall the body
        send_msg(4'd6, 4'd7, 8'd4);
        bus.noc_send_VCready = 1'b0;
        fork
            begin
                send_word(32'hB1, 1'b0);
                send_word(32'hB2, 1'b0);
                send_word(32'hB3, 1'b0);
                send_word(32'hB4, 1'b1);
            end
            begin
                bus.noc_send_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.noc_send_ready = 1'b0;
                @(negedge clk);
                chk("t4_stall_data_ready", bus.data_ready, 0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                bus.noc_send_ready = 1'b1;
            end
        join
        drain();
        bus.noc_send_VCready = 1'b1;
        exp_pkts++;
        chk("t4_pkt_count", pkt_count, exp_pkts);

        // reset mid-body abandons the packet
        send_msg(4'd8, 4'd9, 8'd5);
        send_word(32'hC1, 1'b0);
        send_word(32'hC2, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pkts = 0;
        chk("t5_valid", bus.noc_send_valid, 0);
        chk("t5_flit", bus.noc_send_flit, 0);
        chk("t5_flags", {bus.noc_send_is_header, bus.noc_send_is_tail}, 0);
        chk("t5_pkt_count", pkt_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_data_ready", bus.data_ready, 0);
        send_msg(4'd1, 4'd2, 8'd1);
        send_word(32'hD1, 1'b1);
        drain();
        exp_pkts++;
        chk("t5_new_pkt_count", pkt_count, exp_pkts);

        // packet counter wrap
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_dst_x = 4'd3;
        bus.msg_dst_y = 4'd3;
        bus.msg_len   = 8'd0;
        cnt = 0;
        n = 0;
        while (cnt < 65535 && n < 70000) begin
            @(negedge clk);
            if (bus.msg_ready === 1'b1) begin
                sb.push_back({1'b1, 1'b1, hdr(4'd3, 4'd3, 8'd0)});
                cnt++;
            end
            @(posedge clk);
            n++;
        end
        #1;
        bus.msg_valid = 1'b0;
        chk("t6_accepted", cnt, 65535);
        drain();
        chk("t6_count_max", pkt_count, 16'hFFFF);
        send_msg(4'd3, 4'd3, 8'd0);
        drain();
        chk("t6_count_wrap", pkt_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
